// File: rtl/vu_meter_led.sv
// Peak-hold VU meter: tracks max |sample| of the stereo pair with attack, hold and
// proportional decay, and shows the held peak as an 8-LED thermometer bar.
module vu_meter_led #(
   parameter int HOLD_SAMPLES = 4800,
   parameter int DECAY_SHIFT  = 6,
   parameter int THRESH_BASE  = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid,
   input  logic [15:0] lft_out,
   input  logic [15:0] rht_out,
   output logic [7:0]  LED,
   output logic [14:0] peak
);

   // Width stays at least 1 so HOLD_SAMPLES=0 still elaborates.
   localparam int CNT_W = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_SAMPLES);

   typedef enum logic {ST_HOLD, ST_DECAY} state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] hold_cnt, hold_cnt_next;
   logic [14:0]      peak_next;
   logic [14:0]      mag_l, mag_r, mag;
   logic [14:0]      step, decayed;
   logic [7:0]       led_next;

   // -32768 has no 15-bit magnitude, so it saturates to full scale.
   function automatic logic [14:0] abs_sat(input logic [15:0] x);
      logic [15:0] neg;
      neg = ~x + 16'd1;
      if (!x[15])
         abs_sat = x[14:0];
      else if (x == 16'h8000)
         abs_sat = 15'h7FFF;
      else
         abs_sat = neg[14:0];
   endfunction

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_DECAY;
         hold_cnt <= '0;
         peak     <= '0;
         LED      <= 8'h00;
      end else begin
         state    <= state_next;
         hold_cnt <= hold_cnt_next;
         peak     <= peak_next;
         LED      <= led_next;
      end
   end

   // Next-state logic; everything compares against the pre-update peak.
   always_comb begin
      mag_l         = abs_sat(lft_out);
      mag_r         = abs_sat(rht_out);
      mag           = (mag_l > mag_r) ? mag_l : mag_r;
      step          = peak >> DECAY_SHIFT;
      if (step == 15'd0)
         step = 15'd1;
      decayed       = (peak == 15'd0) ? 15'd0 : (peak - step);
      state_next    = state;
      hold_cnt_next = hold_cnt;
      peak_next     = peak;
      if (valid) begin
         if (mag > peak) begin
            peak_next     = mag;
            hold_cnt_next = HOLD_LOAD;
            state_next    = ST_HOLD;
         end else begin
            case (state)
               ST_HOLD: begin
                  if (hold_cnt != '0) begin
                     hold_cnt_next = hold_cnt - CNT_W'(1);
                  end else begin
                     state_next = ST_DECAY;
                     peak_next  = decayed;
                  end
               end
               default: peak_next = decayed;
            endcase
         end
      end
   end

   // Output logic: bar graph from the registered peak.
   always_comb begin
      led_next = 8'h00;
      for (int i = 0; i < 8; i++)
         led_next[i] = (32'(peak) >= (32'd1 << (THRESH_BASE + i)));
   end

endmodule

// File: tb/tb_vu_meter_led.sv
// Directed bench for vu_meter_led: a sample-count based peak model checked every
// cycle, plus literal expectations for the attack, hold, decay and reset cases.
module tb_vu_meter_led;

   localparam int HOLD   = 4;
   localparam int DSHIFT = 6;
   localparam int TBASE  = 7;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic [15:0] lft_out = 16'h0000;
   logic [15:0] rht_out = 16'h0000;
   logic [7:0]  LED;
   logic [14:0] peak;

   int n_checks = 0;
   int n_errors = 0;

   // Model state: peak, valid samples since the last attack, peak seen by the LED stage.
   int m_peak     = 0;
   int m_since    = HOLD;
   int m_led_peak = 0;

   vu_meter_led #(
      .HOLD_SAMPLES(HOLD),
      .DECAY_SHIFT (DSHIFT),
      .THRESH_BASE (TBASE)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .valid  (valid),
      .lft_out(lft_out),
      .rht_out(rht_out),
      .LED    (LED),
      .peak   (peak)
   );

   always #5 clk = ~clk;

   function automatic int mag1(input logic [15:0] x);
      int v;
      v = int'($signed(x));
      if (v < 0) v = -v;
      if (v > 32767) v = 32767;
      return v;
   endfunction

   function automatic int mag_of(input logic [15:0] l, input logic [15:0] r);
      return (mag1(l) > mag1(r)) ? mag1(l) : mag1(r);
   endfunction

   function automatic int decay_amt(input int p);
      int d;
      d = p / (1 << DSHIFT);
      return (d < 1) ? 1 : d;
   endfunction

   function automatic logic [7:0] led_of(input int p);
      logic [7:0] b;
      b = 8'h00;
      for (int i = 0; i < 8; i++)
         if (p >= (1 << (TBASE + i))) b[i] = 1'b1;
      return b;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // Hold for HOLD non-exceeding samples, decay from the next one on.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_peak     <= 0;
         m_since    <= HOLD;
         m_led_peak <= 0;
      end else begin
         m_led_peak <= m_peak;
         if (valid) begin
            if (mag_of(lft_out, rht_out) > m_peak) begin
               m_peak  <= mag_of(lft_out, rht_out);
               m_since <= 0;
            end else begin
               m_since <= m_since + 1;
               if ((m_since + 1 > HOLD) && (m_peak > 0))
                  m_peak <= m_peak - decay_amt(m_peak);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         check("model_peak", 32'(peak), 32'(m_peak));
         check("model_led", 32'(LED), 32'(led_of(m_led_peak)));
      end
   end

   task automatic send(input logic [15:0] l, input logic [15:0] r);
      @(negedge clk);
      valid   = 1'b1;
      lft_out = l;
      rht_out = r;
      @(negedge clk);
      valid   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst   = 1'b1;
      valid = 1'b0;
      idle(2);
      rst = 1'b0;
   endtask

   logic [15:0] burst_l [5] = '{16'h0100, 16'h0200, 16'hFE80, 16'h0400, 16'h0000};
   logic [15:0] burst_r [5] = '{16'h0000, 16'h0010, 16'h0000, 16'h0000, 16'hFC00};

   initial begin
      idle(3);
      rst = 1'b0;
      idle(1);
      check("reset_peak", 32'(peak), 32'd0);
      check("reset_led", 32'(LED), 32'h00);

      // Attack and two-clock LED latency
      send(16'h4000, 16'h0000);
      check("attack_peak", 32'(peak), 32'd16384);
      check("attack_led_not_yet", 32'(LED), 32'h00);
      idle(1);
      check("attack_led", 32'(LED), 32'hFF);

      // Saturation of -32768
      send(16'h8000, 16'h0100);
      idle(1);
      check("sat_peak", 32'(peak), 32'd32767);
      check("sat_led", 32'(LED), 32'hFF);

      // Right channel wins, negative sample
      do_reset();
      send(16'h0010, 16'hFED4);
      idle(1);
      check("chmax_peak", 32'(peak), 32'd300);
      check("chmax_led", 32'(LED), 32'h03);

      // Hold for 4 samples, then decay by peak>>6
      do_reset();
      send(16'd1000, 16'h0000);
      idle(1);
      check("hold_start_led", 32'(LED), 32'h07);
      for (int k = 0; k < HOLD; k++) begin
         send(16'h0000, 16'h0000);
         check("hold_peak", 32'(peak), 32'd1000);
      end
      send(16'h0000, 16'h0000);
      check("decay1_peak", 32'(peak), 32'd985);
      send(16'h0000, 16'h0000);
      check("decay2_peak", 32'(peak), 32'd970);
      idle(100);
      check("gap_decay_peak", 32'(peak), 32'd970);
      check("gap_decay_led", 32'(LED), 32'h07);
      send(16'h0000, 16'h0000);
      check("after_gap_peak", 32'(peak), 32'd955);
      for (int k = 0; k < 3000 && peak != 15'd0; k++)
         send(16'h0000, 16'h0000);
      send(16'h0000, 16'h0000);
      send(16'h0000, 16'h0000);
      check("decay_floor_peak", 32'(peak), 32'd0);
      check("decay_floor_led", 32'(LED), 32'h00);

      // Re-attack during decay; equal magnitude keeps counting the hold down
      do_reset();
      send(16'd700, 16'h0000);
      for (int k = 0; k < 100 && peak > 15'd600; k++)
         send(16'h0000, 16'h0000);
      check("pre_reattack_led", 32'(LED), 32'h07);
      send(16'd2000, 16'h0000);
      check("reattack_peak", 32'(peak), 32'd2000);
      idle(1);
      check("reattack_led", 32'(LED), 32'h0F);
      send(16'd2000, 16'h0000);
      send(16'h0000, 16'hF830);
      idle(100);
      check("gap_hold_peak", 32'(peak), 32'd2000);
      send(16'd2000, 16'd2000);
      send(16'h0000, 16'h0000);
      check("equal_hold_peak", 32'(peak), 32'd2000);
      send(16'h0000, 16'h0000);
      check("equal_decay_peak", 32'(peak), 32'd1969);

      // Back-to-back strobes
      do_reset();
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         valid   = 1'b1;
         lft_out = burst_l[k];
         rht_out = burst_r[k];
         @(negedge clk);
      end
      valid = 1'b0;
      check("burst_peak", 32'(peak), 32'd1024);
      idle(1);
      check("burst_led", 32'(LED), 32'h0F);

      // Asynchronous reset mid-stream; valid during reset is ignored
      send(16'd20000, 16'h0000);
      idle(2);
      check("pre_async_led", 32'(LED), 32'hFF);
      @(posedge clk);
      #3;
      rst     = 1'b1;
      valid   = 1'b1;
      lft_out = 16'h7000;
      #1;
      check("async_peak", 32'(peak), 32'd0);
      check("async_led", 32'(LED), 32'h00);
      idle(2);
      valid = 1'b0;
      rst   = 1'b0;
      idle(2);
      check("post_reset_peak", 32'(peak), 32'd0);
      check("post_reset_led", 32'(LED), 32'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
